// File: rtl/exe_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// exe_muldiv_pkg
//   Shared definitions for the EXE-stage RV32M multiply/divide unit:
//   operand width, funct3 encodings, FSM state encoding, divider counter
//   sizing and a small absolute-value helper.
//   Optional feature macro used by the top: MULDIV_REMCACHE_EN.
// ---------------------------------------------------------------------------
package exe_muldiv_pkg;

  localparam int MD_XLEN  = 32;
  localparam int MD_CNT_W = 6;

  // Value of the divider iteration counter during the final quotient step.
  localparam logic [MD_CNT_W-1:0] MD_LAST_STEP = MD_CNT_W'(MD_XLEN - 1);

  // funct3 encodings of the M extension
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  // Magnitude of v when it is interpreted as signed (en=1); v unchanged
  // otherwise. 0x80000000 maps onto itself, which the unsigned divider
  // core handles correctly as 2^31.
  function automatic logic [MD_XLEN-1:0] md_abs(input logic [MD_XLEN-1:0] v,
                                                input logic               en);
    return (en && v[MD_XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/exe_muldiv_divcore.sv
// ---------------------------------------------------------------------------
// muldiv_divcore
//   Unsigned radix-2 restoring divider, one quotient bit per step.
//   i_load captures dividend/divisor and clears the iteration counter;
//   each i_step cycle produces one quotient bit. After MD_XLEN steps
//   o_quot/o_rem hold the unsigned quotient and remainder.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     i_load            load operands, clear counter
//     i_step            perform one iteration
//     i_dividend        unsigned dividend
//     i_divisor         unsigned divisor (non-zero when stepping)
//     o_quot, o_rem     running quotient / partial remainder
//     o_count           number of iterations completed since load
// ---------------------------------------------------------------------------
module muldiv_divcore
  import exe_muldiv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic                i_step,
  input  logic [MD_XLEN-1:0]  i_dividend,
  input  logic [MD_XLEN-1:0]  i_divisor,
  output logic [MD_XLEN-1:0]  o_quot,
  output logic [MD_XLEN-1:0]  o_rem,
  output logic [MD_CNT_W-1:0] o_count
);

  logic [MD_XLEN-1:0]  r_quot;   // dividend bits shift out, quotient bits shift in
  logic [MD_XLEN-1:0]  r_rem;
  logic [MD_XLEN-1:0]  r_div;
  logic [MD_CNT_W-1:0] r_count;

  logic [MD_XLEN:0]    w_shift;
  logic [MD_XLEN+1:0]  w_diff;
  logic                w_ge;

  // Partial remainder is always below the divisor, so the shifted value is
  // below 2*divisor and one extra guard bit is enough for the sign test.
  assign w_shift = {r_rem, r_quot[MD_XLEN-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_div};
  assign w_ge    = ~w_diff[MD_XLEN+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quot  <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_quot  <= i_dividend;
      r_rem   <= '0;
      r_div   <= i_divisor;
      r_count <= '0;
    end else if (i_step) begin
      r_rem   <= w_ge ? w_diff[MD_XLEN-1:0] : w_shift[MD_XLEN-1:0];
      r_quot  <= {r_quot[MD_XLEN-2:0], w_ge};
      r_count <= r_count + 1'b1;
    end
  end

  assign o_quot  = r_quot;
  assign o_rem   = r_rem;
  assign o_count = r_count;

endmodule

// File: rtl/exe_muldiv.sv
// ---------------------------------------------------------------------------
// exe_muldiv
//   Iterative RV32M multiply/divide unit living in the EXE stage. While an
//   operation is in flight it requests a pipeline freeze through stall; the
//   result is presented with a one-cycle done pulse in the DONE state, where
//   stall is low so EXE/MEM captures it.
//   Latency (start in cycle 0): MUL* done in cycle 1+MUL_STAGES, DIV/REM in
//   cycle 34, divide-by-zero / signed overflow in cycle 1.
//   Optional feature: define MULDIV_REMCACHE_EN to keep the last completed
//   divide (operands, signedness, quotient, remainder); a later divide with
//   identical operands and signedness finishes in cycle 1. Only rst clears it.
//   Ports:
//     clk, rst       clock, asynchronous active-high reset
//     start          M-extension op present in EXE and not being flushed
//     flush          kill any in-flight op (wins over start)
//     funct3         operation select (MUL..REMU)
//     opA, opB       forwarded rs1 / rs2
//     rd_in          destination register of the op
//     stall          freeze request to the hazard unit
//     done           one-cycle result-valid pulse
//     result         result, valid while done=1
//     rd_out         destination register of the result
// ---------------------------------------------------------------------------
module exe_muldiv #(
  parameter int MUL_STAGES = 1,   // 1..3
  parameter int XLEN       = 32   // only 32 supported
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [4:0]      rd_in,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  import exe_muldiv_pkg::*;

  localparam logic [1:0] L_MUL_LAST = 2'(MUL_STAGES - 1);

  md_state_e r_state;
  md_state_e w_state_next;

  logic [2:0]        r_funct3;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_op_a;
  logic [XLEN-1:0]   r_op_b;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [1:0]        r_mcnt;
  logic [XLEN-1:0]   r_result;

  // ---------------- input decode (accept cycle) ----------------
  logic w_accept_state, w_accept;
  logic w_in_div_op, w_in_sdiv, w_in_rem;
  logic w_div_zero, w_div_ovf, w_div_special;
  logic [XLEN-1:0] w_special_res;
  logic w_cache_hit;
  logic [XLEN-1:0] w_cache_res;

  assign w_accept_state = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept       = start && !flush && w_accept_state;

  assign w_in_sdiv   = (funct3 == MD_DIV) || (funct3 == MD_REM);
  assign w_in_rem    = (funct3 == MD_REM) || (funct3 == MD_REMU);
  assign w_in_div_op = w_in_rem || (funct3 == MD_DIV) || (funct3 == MD_DIVU);

  assign w_div_zero    = (opB == '0);
  assign w_div_ovf     = w_in_sdiv && (opA == {1'b1, {(XLEN-1){1'b0}}}) && (opB == '1);
  assign w_div_special = w_div_zero || w_div_ovf;

  // Zero divisor: q=all ones, r=dividend. Overflow: q=dividend (0x80000000), r=0.
  always_comb begin
    w_special_res = '0;
    if (w_div_zero)
      w_special_res = w_in_rem ? opA : '1;
    else if (!w_in_rem)
      w_special_res = opA;
  end

  // ---------------- multiplier ----------------
  logic w_a_signed, w_b_signed;
  logic [2*XLEN-1:0] w_mul_a_ext, w_mul_b_ext, w_prod, w_mul_final;
  logic w_mul_last;

  assign w_a_signed = (r_funct3 == MD_MULH) || (r_funct3 == MD_MULHSU);
  assign w_b_signed = (r_funct3 == MD_MULH);

  // Extending both operands to 64 bits makes a plain 64-bit product correct
  // for every signed/unsigned combination.
  assign w_mul_a_ext = {{XLEN{w_a_signed & r_op_a[XLEN-1]}}, r_op_a};
  assign w_mul_b_ext = {{XLEN{w_b_signed & r_op_b[XLEN-1]}}, r_op_b};
  assign w_prod      = w_mul_a_ext * w_mul_b_ext;
  assign w_mul_last  = (r_mcnt == L_MUL_LAST);

  // r_result is the last of the MUL_STAGES registers; the remaining
  // MUL_STAGES-1 registers form the chain below.
  generate
    if (MUL_STAGES > 1) begin : g_pipe
      for (genvar gi = 0; gi < MUL_STAGES - 1; gi++) begin : g_stage
        logic [2*XLEN-1:0] r_stage;
        if (gi == 0) begin : g_first
          always_ff @(posedge clk or posedge rst) begin
            if (rst) r_stage <= '0;
            else     r_stage <= w_prod;
          end
        end else begin : g_next
          always_ff @(posedge clk or posedge rst) begin
            if (rst) r_stage <= '0;
            else     r_stage <= g_stage[gi-1].r_stage;
          end
        end
      end
      assign w_mul_final = g_stage[MUL_STAGES-2].r_stage;
    end else begin : g_nopipe
      assign w_mul_final = w_prod;
    end
  endgenerate

  // ---------------- divider ----------------
  logic [XLEN-1:0]     w_quot, w_rem, w_q_fixed, w_r_fixed, w_fix_res;
  logic [MD_CNT_W-1:0] w_div_count;
  logic                w_r_is_rem;

  muldiv_divcore u_divcore (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept && w_in_div_op),
    .i_step     (r_state == ST_DIV),
    .i_dividend (md_abs(opA, w_in_sdiv)),
    .i_divisor  (md_abs(opB, w_in_sdiv)),
    .o_quot     (w_quot),
    .o_rem      (w_rem),
    .o_count    (w_div_count)
  );

  assign w_r_is_rem = (r_funct3 == MD_REM) || (r_funct3 == MD_REMU);
  assign w_q_fixed  = r_neg_q ? (~w_quot + 1'b1) : w_quot;
  assign w_r_fixed  = r_neg_r ? (~w_rem + 1'b1)  : w_rem;
  assign w_fix_res  = w_r_is_rem ? w_r_fixed : w_q_fixed;

  // ---------------- optional result cache ----------------
`ifdef MULDIV_REMCACHE_EN
  logic            r_c_valid, r_c_s;
  logic [XLEN-1:0] r_c_a, r_c_b, r_c_q, r_c_r;

  assign w_cache_hit = r_c_valid && (r_c_a == opA) && (r_c_b == opB) && (r_c_s == w_in_sdiv);
  assign w_cache_res = w_in_rem ? r_c_r : r_c_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_valid <= 1'b0;
      r_c_s     <= 1'b0;
      r_c_a     <= '0;
      r_c_b     <= '0;
      r_c_q     <= '0;
      r_c_r     <= '0;
    end else if (r_state == ST_FIX && !flush) begin
      r_c_valid <= 1'b1;
      r_c_s     <= (r_funct3 == MD_DIV) || (r_funct3 == MD_REM);
      r_c_a     <= r_op_a;
      r_c_b     <= r_op_b;
      r_c_q     <= w_q_fixed;
      r_c_r     <= w_r_fixed;
    end
  end
`else
  assign w_cache_hit = 1'b0;
  assign w_cache_res = '0;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        stall = start;
        done  = (r_state == ST_DONE);
        if (w_accept) begin
          if (!w_in_div_op)
            w_state_next = ST_MUL;
          else if (w_div_special || w_cache_hit)
            w_state_next = ST_DONE;
          else
            w_state_next = ST_DIV;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_MUL: begin
        stall = 1'b1;
        if (w_mul_last) w_state_next = ST_DONE;
      end
      ST_DIV: begin
        stall = 1'b1;
        if (w_div_count == MD_LAST_STEP) w_state_next = ST_FIX;
      end
      ST_FIX: begin
        stall        = 1'b1;
        w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (flush) w_state_next = ST_IDLE;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_funct3 <= '0;
      r_rd     <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_mcnt   <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_funct3 <= funct3;
        r_rd     <= rd_in;
        r_op_a   <= opA;
        r_op_b   <= opB;
        r_neg_q  <= w_in_sdiv && (opA[XLEN-1] ^ opB[XLEN-1]);
        r_neg_r  <= w_in_sdiv && opA[XLEN-1];
        r_mcnt   <= '0;
        if (w_in_div_op) begin
          if (w_div_special)
            r_result <= w_special_res;
          else if (w_cache_hit)
            r_result <= w_cache_res;
        end
      end else if (r_state == ST_MUL) begin
        r_mcnt <= r_mcnt + 1'b1;
        if (w_mul_last)
          r_result <= (r_funct3 == MD_MUL) ? w_mul_final[XLEN-1:0]
                                           : w_mul_final[2*XLEN-1:XLEN];
      end else if (r_state == ST_FIX) begin
        r_result <= w_fix_res;
      end
    end
  end

  assign result = r_result;
  assign rd_out = r_rd;

endmodule

// File: tb/tb_exe_muldiv.sv
module tb_exe_muldiv;

  localparam int MUL_STAGES = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [4:0]  rd_in;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  exe_muldiv #(.MUL_STAGES(MUL_STAGES), .XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .opA    (opA),
    .opB    (opB),
    .rd_in  (rd_in),
    .stall  (stall),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

`ifdef MULDIV_REMCACHE_EN
  bit          c_valid = 1'b0;
  bit          c_s;
  logic [31:0] c_a, c_b;
`endif

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics from plain integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'(signed'(a));
    longint      sb = longint'(signed'(b));
    longint      ua = longint'({32'h0, a});
    longint      ub = longint'({32'h0, b});
    logic [63:0] p;
    int          ia = signed'(a);
    int          ib = signed'(b);
    bit          sgn = (f3 == 3'd4) || (f3 == 3'd6);
    bit          is_rem = (f3 == 3'd6) || (f3 == 3'd7);
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      default: begin
        if (b == 32'h0) return is_rem ? a : 32'hFFFFFFFF;
        if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) return is_rem ? 32'h0 : 32'h80000000;
        if (sgn) return is_rem ? 32'(ia % ib) : 32'(ia / ib);
        return is_rem ? (a % b) : (a / b);
      end
    endcase
  endfunction

  task automatic model_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
    bit s;
    bit special;
    res = ref_result(f3, a, b);
    s = (f3 == 3'd4) || (f3 == 3'd6);
    special = (b == 32'h0) || (s && a == 32'h80000000 && b == 32'hFFFFFFFF);
    if (f3 < 3'd4)
      lat = 1 + MUL_STAGES;
    else if (special)
      lat = 1;
`ifdef MULDIV_REMCACHE_EN
    else if (c_valid && c_a == a && c_b == b && c_s == s)
      lat = 1;
    else begin
      lat = 34;
      c_valid = 1'b1; c_a = a; c_b = b; c_s = s;
    end
`else
    else
      lat = 34;
`endif
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    funct3 = f3; opA = a; opB = b; rd_in = rd; start = 1'b1;
    #1;
    check("stall_cycle0", {31'h0, stall}, 32'h1);
  endtask

  task automatic finish_op(input string tag, input logic [31:0] exp_res, input logic [4:0] exp_rd,
                           input int exp_lat, output int cyc);
    bit stall_ok = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      cyc++;
      if (done !== 1'b1 && stall !== 1'b1) stall_ok = 1'b0;
    end while (done !== 1'b1 && cyc < 80);
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_rd"}, {27'h0, rd_out}, {27'h0, exp_rd});
    check({tag, "_stall_done"}, {31'h0, stall}, 32'h0);
    check({tag, "_stall_busy"}, {31'h0, stall_ok}, 32'h1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit use_exp, input logic [31:0] exp_res);
    logic [31:0] mres;
    int lat;
    int cyc;
    model_op(f3, a, b, mres, lat);
    if (use_exp) mres = exp_res;
    issue(f3, a, b, rd);
    finish_op(tag, mres, rd, lat, cyc);
    $display("[TB] %s f3=%0d a=%h b=%h rd=%0d -> result=%h rd_out=%0d cycles=%0d",
             tag, f3, a, b, rd, result, rd_out, cyc);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom % 64);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    bit saw_done;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = 3'd0; opA = 32'h0; opB = 32'h0; rd_in = 5'd0;
    #1;
    check("reset_done",   {31'h0, done},   32'h0);
    check("reset_stall",  {31'h0, stall},  32'h0);
    check("reset_result", result,          32'h0);
    check("reset_rd",     {27'h0, rd_out}, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Directed cases (expected values fixed by hand); each op after the
    // first is issued in the previous op's DONE cycle (back-to-back).
    run_op("mul_7x-3",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd1, 1'b1, 32'hFFFFFFEB);
    run_op("mulhu_max",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 1'b1, 32'hFFFFFFFE);
    run_op("mulh_max",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 1'b1, 32'h00000000);
    run_op("mulhsu_m1",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 1'b1, 32'hFFFFFFFF);
    run_op("div_-20_6",   3'd4, 32'hFFFFFFEC, 32'd6,        5'd5, 1'b1, 32'hFFFFFFFD);
    run_op("rem_-20_6",   3'd6, 32'hFFFFFFEC, 32'd6,        5'd6, 1'b1, 32'hFFFFFFFE);
    run_op("divu_5_0",    3'd5, 32'd5,        32'd0,        5'd7, 1'b1, 32'hFFFFFFFF);
    run_op("rem_ovf",     3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd8, 1'b1, 32'h00000000);
    run_op("div_ovf",     3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd9, 1'b1, 32'h80000000);
    run_op("div_100_7",   3'd4, 32'd100,      32'd7,        5'd10, 1'b1, 32'd14);
    run_op("rem_100_7",   3'd6, 32'd100,      32'd7,        5'd11, 1'b1, 32'd2);

    // Flush a DIV in its 10th cycle: no done, stall drops, then a MUL runs.
    issue(3'd4, 32'd1000, 32'd3, 5'd12);
    saw_done = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("flush_no_done_before", {31'h0, saw_done}, 32'h0);
    check("flush_done_after",     {31'h0, done},     32'h0);
    check("flush_stall_after",    {31'h0, stall},    32'h0);
    $display("[TB] flush div 1000/3 at cycle 10 -> done=%0b stall=%0b", done, stall);
    run_op("mul_after_flush", 3'd0, 32'd123, 32'd456, 5'd13, 1'b1, 32'd56088);

    // Randomized ops against the reference model, with occasional idle gaps.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom % 8);
      a  = rnd_op();
      b  = rnd_op();
      if ($urandom % 3 == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #2;
      end
      run_op($sformatf("rand%0d", i), f3, a, b, 5'($urandom), 1'b0, 32'h0);
    end

    // Asynchronous reset in the middle of a DIV.
    run_op("pre_reset_mul", 3'd0, 32'd6, 32'd7, 5'd20, 1'b1, 32'd42);
    issue(3'd4, 32'd1000, 32'd3, 5'd21);
    repeat (5) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("async_rst_done",   {31'h0, done},   32'h0);
    check("async_rst_stall",  {31'h0, stall},  32'h0);
    check("async_rst_result", result,          32'h0);
    check("async_rst_rd",     {27'h0, rd_out}, 32'h0);
    $display("[TB] async reset mid-div -> done=%0b result=%h rd_out=%0d", done, result, rd_out);
`ifdef MULDIV_REMCACHE_EN
    c_valid = 1'b0;
`endif
    @(posedge clk);
    #2 rst = 1'b0;

    // After reset the divide must take the full path again.
    run_op("post_rst_div_100_7", 3'd4, 32'd100, 32'd7, 5'd22, 1'b1, 32'd14);
    run_op("post_rst_rem_100_7", 3'd6, 32'd100, 32'd7, 5'd23, 1'b1, 32'd2);
    run_op("post_rst_mul",       3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd24, 1'b1, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_muldiv.md
Name: exe_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EXE stage, downstream of the ID/EXE pipeline register.
- Consumes the forwarded operands, funct3 and rd that EXE holds, and returns a 32-bit result.
- Holds a stall to the hazard unit while an operation is in flight, so the ID/EXE and EXE/MEM registers freeze until the result is ready.

Parameters:
- MUL_STAGES, 1: registered pipeline depth after the 32x32 product; legal values 1..3.
- XLEN, 32: operand width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high; clears all state
- start  in  1  M-extension op present in EXE and not being flushed
- flush  in  1  kills any in-flight op
- funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- opA  in  32  forwarded rs1
- opB  in  32  forwarded rs2
- rd_in  in  5  destination register
- stall  out  1  freeze request to the hazard unit
- done  out  1  one-cycle result-valid pulse
- result  out  32  result; valid only while done=1
- rd_out  out  5  destination register of the result

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, result=0, rd_out=0, done=0, iteration counter=0.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- start is accepted only in IDLE or DONE. start in MUL, DIV or FIX is ignored, because stall already holds EXE.
- Combinational stall = (state in {MUL, DIV, FIX}) or (start and state in {IDLE, DONE}). stall is low in the DONE cycle, so the pipeline advances and captures result.
- MUL path:
  - Accept latches operands and state goes to MUL.
  - Signed or unsigned 64-bit product per funct3: MULHSU treats opA as signed and opB as unsigned.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
  - Stays in MUL for MUL_STAGES cycles, then goes to DONE.
  - With start in cycle 0, done=1 in cycle 1+MUL_STAGES.
- DIV path:
  - Accept latches |opA| and |opB| (for signed ops) plus the sign flags, and state goes to DIV.
  - Radix-2 restoring division, one quotient bit per cycle, 32 cycles.
  - FIX applies the signs: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - With start in cycle 0, done=1 in cycle 34.
- Special cases are resolved in the accept cycle, bypass DIV/FIX and go straight to DONE, so done=1 in cycle 1:
  - divisor=0: quotient=0xFFFFFFFF; remainder=opA.
  - Signed overflow (opA=0x80000000, opB=0xFFFFFFFF): quotient=0x80000000; remainder=0.
- DONE:
  - done=1 for exactly one cycle; result and rd_out are stable.
  - Next state is IDLE, or a new op if start is high in that cycle (back-to-back).
- flush in any state:
  - Next state is IDLE; no done is produced.
  - flush has priority over start in the same cycle.
- All arithmetic is modulo 2^32; no exceptions are raised.

Optional Feature:
- Macro: MULDIV_REMCACHE_EN.
- With the macro defined:
  - Each completed DIV/DIVU/REM/REMU stores opA, opB, signedness, quotient and remainder.
  - A later divide op with identical opA, opB and signedness goes straight to DONE, with done=1 in cycle 1.
  - The cache is invalidated by rst only.
- Without the macro: no cache; every divide takes the full latency.

Decomposition:
- Shared package: funct3 encodings (MD_MUL..MD_REMU), FSM state enum, XLEN.
- One sub-module, muldiv_divcore: the 32-iteration restoring divider with load/step/count interface, instantiated once.

Test Plan:
- MUL: opA=7, opB=-3 → done in cycle 2 (MUL_STAGES=1), result=0xFFFFFFEB; stall high only in cycles 0-1.
- MULHU: 0xFFFFFFFF × 0xFFFFFFFF → result=0xFFFFFFFE; MULH on the same operands → 0x00000000.
- DIV: -20 / 6 → done in cycle 34, result=0xFFFFFFFD. REM on the same operands → result=0xFFFFFFFE.
- Div by zero and overflow:
  - DIVU 5/0 → 0xFFFFFFFF, done in cycle 1.
  - REM 0x80000000 / -1 → 0, done in cycle 1.
- flush at cycle 10 of a DIV → no done, stall low next cycle; a new MUL started the following cycle completes correctly.
- Reset, then DONE-cycle restart:
  - rst asserted mid-DIV → all outputs 0 immediately (asynchronous).
  - A new start issued in the DONE cycle is accepted back-to-back.
  - With MULDIV_REMCACHE_EN: DIV 100/7 then REM 100/7 → REM done in cycle 1, result=2.
